store_unit: RTL and testbench

Memory-stage store path of the RISC-V core: takes a store request (rs2 data, effective byte address, funct3), produces word-aligned bus writes with byte enables and lane-shifted data, and signals completion. It complements the load-data extender on the same data-memory interface. Misaligned halfword/word stores crossing a word boundary are split into two word-aligned bus transactions rather than trapped.

---
 rtl/store_unit.sv | 183 ++++++++++++++++++
 tb/tb_store_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// Memory-stage store path: converts a byte/half/word store into one or two
// word-aligned bus writes with byte enables, splitting stores that cross a word.
module store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_st_valid,
    output logic        o_st_ready,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_mem_req,
    input  logic        i_mem_gnt,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    output logic        o_done,
    output logic        o_err
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ0 = 2'd1,
        S_REQ1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_mem_req;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [BW-1:0]   r_mem_be;
    logic            r_done;
    logic            r_err;

    logic [AW-1:0]   r_hi_addr;
    logic [DW-1:0]   r_hi_wdata;
    logic [BW-1:0]   r_hi_be;

    logic            w_accept;
    logic            w_legal;
    logic [2*BW-1:0] w_mask_base;
    logic [2*DW-1:0] w_data_base;
    logic [2*BW-1:0] w_mask8;
    logic [2*DW-1:0] w_data64;
    logic [AW-1:0]   w_lo_addr;

    logic            w_mem_req_nxt;
    logic [AW-1:0]   w_mem_addr_nxt;
    logic [DW-1:0]   w_mem_wdata_nxt;
    logic [BW-1:0]   w_mem_be_nxt;
    logic            w_done_nxt;
    logic            w_err_nxt;

    assign o_st_ready  = (r_state == S_IDLE);
    assign o_mem_req   = r_mem_req;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_be    = r_mem_be;
    assign o_done      = r_done;
    assign o_err       = r_err;

    assign w_accept  = i_st_valid && (r_state == S_IDLE);
    assign w_legal   = (i_funct3 <= 3'd2);
    assign w_lo_addr = {i_addr[AW-1:2], 2'b00};

    // Size-dependent lane mask and zero-extended data before lane shifting
    always_comb begin
        w_mask_base = 8'h0F;
        w_data_base = {32'd0, i_wdata};
        case (i_funct3)
            3'd0: begin
                w_mask_base = 8'h01;
                w_data_base = {56'd0, i_wdata[7:0]};
            end
            3'd1: begin
                w_mask_base = 8'h03;
                w_data_base = {48'd0, i_wdata[15:0]};
            end
            default: ;
        endcase
    end

    // 8-lane window spanning the addressed word and the one after it
    assign w_mask8  = w_mask_base << i_addr[1:0];
    assign w_data64 = w_data_base << {i_addr[1:0], 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next values of the registered bus/status outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_be_nxt    = r_mem_be;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_mem_req_nxt = 1'b0;
                if (w_accept) begin
                    if (w_legal) begin
                        w_state_nxt     = S_REQ0;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_addr_nxt  = w_lo_addr;
                        w_mem_be_nxt    = w_mask8[BW-1:0];
                        w_mem_wdata_nxt = w_data64[DW-1:0];
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_REQ0: begin
                if (i_mem_gnt) begin
                    if (r_hi_be != '0) begin
                        w_state_nxt     = S_REQ1;
                        w_mem_addr_nxt  = r_hi_addr;
                        w_mem_be_nxt    = r_hi_be;
                        w_mem_wdata_nxt = r_hi_wdata;
                    end else begin
                        w_state_nxt   = S_IDLE;
                        w_mem_req_nxt = 1'b0;
                        w_done_nxt    = 1'b1;
                    end
                end
            end
            S_REQ1: begin
                if (i_mem_gnt) begin
                    w_state_nxt   = S_IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_done_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_req   <= w_mem_req_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Upper-word transaction is captured at accept time; wraps past 0xFFFFFFFC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_addr  <= '0;
            r_hi_wdata <= '0;
            r_hi_be    <= '0;
        end else if (w_accept && w_legal) begin
            r_hi_addr  <= w_lo_addr + AW'(4);
            r_hi_wdata <= w_data64[2*DW-1:DW];
            r_hi_be    <= w_mask8[2*BW-1:BW];
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: aligned, split, stalled, wrapping, illegal and reset-abort stores.
module tb_store_unit;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        err;

    int n_checks;
    int n_errors;

    store_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_st_valid  (st_valid),
        .o_st_ready  (st_ready),
        .i_funct3    (funct3),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_mem_req   (mem_req),
        .i_mem_gnt   (mem_gnt),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_be    (mem_be),
        .o_done      (done),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_txn(input string tag, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d);
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_be"}, 32'(mem_be), 32'(be));
        chk({tag, "_wdata"}, mem_wdata, d);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rdy"}, 32'(st_ready), 32'd0);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_rdy"}, 32'(st_ready), 32'd1);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        funct3   = f3;
        addr     = a;
        wdata    = d;
        tick();
        st_valid = 1'b0;
        funct3   = 3'd2;
        addr     = 32'hDEAD_BEEF;
        wdata    = 32'h5A5A_5A5A;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        st_valid = 1'b0;
        funct3   = 3'd0;
        addr     = '0;
        wdata    = '0;
        mem_gnt  = 1'b0;
        #3;
        chk("rst_rdy", 32'(st_ready), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        #9 rst_n = 1'b1;
        tick();

        // SB, aligned lane 3
        mem_gnt = 1'b1;
        issue(3'd0, 32'h0000_1003, 32'h1234_56AB);
        chk_txn("sb", 32'h0000_1000, 4'b1000, 32'hAB00_0000);
        tick();
        chk_done("sb");
        tick();
        chk("sb_done_pulse", 32'(done), 32'd0);

        // SH, upper half
        issue(3'd1, 32'h0000_2002, 32'h0000_BEEF);
        chk_txn("sh", 32'h0000_2000, 4'b1100, 32'hBEEF_0000);
        tick();
        chk_done("sh");
        tick();

        // SW misaligned, split into two
        issue(3'd2, 32'h0000_3001, 32'hAABB_CCDD);
        chk_txn("sw_lo", 32'h0000_3000, 4'b1110, 32'hBBCC_DD00);
        tick();
        chk_txn("sw_hi", 32'h0000_3004, 4'b0001, 32'h0000_00AA);
        tick();
        chk_done("sw");
        tick();
        chk("sw_done_pulse", 32'(done), 32'd0);

        // SH crossing 0xFFFFFFFF with 3 stall cycles per request
        mem_gnt = 1'b0;
        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_1122);
        for (int i = 0; i < 3; i++) begin
            chk_txn("wrap_lo_stall", 32'hFFFF_FFFC, 4'b1000, 32'h2200_0000);
            tick();
        end
        chk_txn("wrap_lo", 32'hFFFF_FFFC, 4'b1000, 32'h2200_0000);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_txn("wrap_hi_stall", 32'h0000_0000, 4'b0001, 32'h0000_0011);
            tick();
        end
        chk_txn("wrap_hi", 32'h0000_0000, 4'b0001, 32'h0000_0011);
        mem_gnt = 1'b1;
        tick();
        chk_done("wrap");
        tick();

        // Illegal funct3
        issue(3'd3, 32'h0000_0010, 32'h0000_0000);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_rdy", 32'(st_ready), 32'd1);
        chk("ill_req", 32'(mem_req), 32'd0);
        chk("ill_done", 32'(done), 32'd0);
        tick();
        chk("ill_err_pulse", 32'(err), 32'd0);
        chk("ill_req2", 32'(mem_req), 32'd0);
        chk("ill_done2", 32'(done), 32'd0);

        // Reset during REQ1 of a split SW
        issue(3'd2, 32'h0000_0005, 32'h0102_0304);
        chk_txn("abort_lo", 32'h0000_0004, 4'b1110, 32'h0203_0400);
        tick();
        chk_txn("abort_hi", 32'h0000_0008, 4'b0001, 32'h0000_0001);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_rdy", 32'(st_ready), 32'd1);
        #2 rst_n = 1'b1;
        tick();
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_idle_req", 32'(mem_req), 32'd0);

        // Fresh aligned SW after reset
        issue(3'd2, 32'h0000_0004, 32'hCAFE_F00D);
        chk_txn("post", 32'h0000_0004, 4'b1111, 32'hCAFE_F00D);
        tick();
        chk_done("post");
        tick();
        chk("post_done_pulse", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
